// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG collector: FSM state encoding,
// default parameter values and the counter-width helper.
package trng_pkg;

  typedef enum logic [1:0] {IDLE, WARMUP, COLLECT, FAIL} trng_state_e;

  localparam int DEF_WORD_WIDTH    = 32;
  localparam int DEF_WARMUP_CYCLES = 256;
  localparam int DEF_REP_LIMIT     = 32;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs consecutive raw samples, 10 -> 1, 01 -> 0,
// 00/11 -> nothing. The output is combinational on the second sample of a pair.
module trng_vn_debias (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic raw,
  output logic bit_valid,
  output logic bit_out
);

  logic phase;
  logic first;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
      first <= 1'b0;
    end else if (clear) begin
      phase <= 1'b0;
      first <= 1'b0;
    end else if (en) begin
      phase <= ~phase;
      if (!phase) first <= raw;
    end
  end

  assign bit_valid = en & phase & (first ^ raw);
  assign bit_out   = first;

endmodule

// File: rtl/trng_collector.sv
// TRNG front end: synchronises the raw oscillator bit, discards warm-up samples,
// runs a repetition-count health test, debiases and packs words for a valid/ready sink.
module trng_collector
  import trng_pkg::*;
#(
  parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  trng_en,
  input  logic                  trng_bit,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  health_fail_o
);

  localparam int CW = cnt_width(WORD_WIDTH);
  localparam int WW = cnt_width(WARMUP_CYCLES);
  localparam int RW = cnt_width(REP_LIMIT);

  trng_state_e           state;
  logic                  sync1, raw, raw_q;
  logic [WW-1:0]         warm_cnt;
  logic [RW-1:0]         run;
  logic [WORD_WIDTH-1:0] sh;
  logic [CW-1:0]         cnt;
  logic                  vn_clear, vn_en, bit_valid, bit_out;
  logic                  full, slot_free, accept, trip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      raw   <= 1'b0;
      raw_q <= 1'b0;
    end else begin
      sync1 <= trng_bit;
      raw   <= sync1;
      raw_q <= raw;
    end
  end

  assign vn_en     = (state == COLLECT);
  assign vn_clear  = (state == IDLE) ? enable : !enable;
  assign full      = (cnt == CW'(WORD_WIDTH));
  assign accept    = valid_o && ready_i;
  assign slot_free = !valid_o || ready_i;
  assign trip      = (run == RW'(REP_LIMIT));

  trng_vn_debias u_debias (
    .clk       (clk),
    .reset     (reset),
    .clear     (vn_clear),
    .en        (vn_en),
    .raw       (raw),
    .bit_valid (bit_valid),
    .bit_out   (bit_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      trng_en       <= 1'b0;
      warm_cnt      <= '0;
      run           <= '0;
      sh            <= '0;
      cnt           <= '0;
      data_o        <= '0;
      valid_o       <= 1'b0;
      health_fail_o <= 1'b0;
    end else begin
      if (accept) valid_o <= 1'b0;
      // Dropping enable keeps a pending output word; only FAIL discards it.
      if (state != IDLE && !enable) begin
        state   <= IDLE;
        trng_en <= 1'b0;
        cnt     <= '0;
        sh      <= '0;
        run     <= '0;
      end else begin
        case (state)
          IDLE: if (enable) begin
            state         <= WARMUP;
            trng_en       <= 1'b1;
            warm_cnt      <= '0;
            cnt           <= '0;
            health_fail_o <= 1'b0;
          end
          WARMUP: begin
            warm_cnt <= warm_cnt + WW'(1);
            if (warm_cnt == WW'(WARMUP_CYCLES - 1)) begin
              state <= COLLECT;
              run   <= RW'(1);
            end
          end
          COLLECT: if (trip) begin
            state         <= FAIL;
            trng_en       <= 1'b0;
            health_fail_o <= 1'b1;
            valid_o       <= 1'b0;
            cnt           <= '0;
            sh            <= '0;
          end else begin
            if (raw != raw_q)          run <= RW'(1);
            else if (!trip)            run <= run + RW'(1);
            if (full && slot_free) begin
              data_o  <= sh;
              valid_o <= 1'b1;
              if (bit_valid) begin
                sh  <= {sh[WORD_WIDTH-2:0], bit_out};
                cnt <= CW'(1);
              end else begin
                cnt <= '0;
              end
            end else if (!full && bit_valid) begin
              sh  <= {sh[WORD_WIDTH-2:0], bit_out};
              cnt <= cnt + CW'(1);
            end
          end
          default: ;  // FAIL holds until enable drops
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Bench for trng_collector: table of directed words, multi-cycle corner
// sequences, and randomized streams checked against a pair/word list model.
module tb_trng_collector;

  localparam int W  = 8;
  localparam int WU = 4;
  localparam int RL = 6;

  logic         clk = 1'b0;
  logic         reset, enable, trng_en, trng_bit, valid_o, ready_i, health_fail_o;
  logic [W-1:0] data_o;

  int checks   = 0;
  int errors   = 0;
  int idle_cnt = 0;

  typedef struct {
    logic [23:0] bits;
    int          n;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[5];

  trng_collector #(.WORD_WIDTH(W), .WARMUP_CYCLES(WU), .REP_LIMIT(RL)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .trng_en       (trng_en),
    .trng_bit      (trng_bit),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .health_fail_o (health_fail_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b);
    trng_bit = b;
    tick();
  endtask

  task automatic drive_pair(input logic v);
    drive(v);
    drive(~v);
  endtask

  task automatic drive_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) drive_pair(w[i]);
  endtask

  // Non-emitting filler: pairs 11,00,11,... with short runs.
  task automatic drive_idle(input int n);
    for (int k = 0; k < n; k++) begin
      drive((idle_cnt % 4) < 2);
      idle_cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; ready_i = 1'b0; trng_bit = 1'b0;
    idle_cnt = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // Raise enable and supply the three samples that precede the first collected one.
  task automatic start_collect();
    enable = 1'b1;
    drive(1'b0); drive(1'b1); drive(1'b0);
  endtask

  task automatic rnd_round(input int nbits);
    logic       q[$];
    logic [7:0] expq[$];
    logic [7:0] acc;
    logic       last, b, tval;
    int         runlen, waitc, got, nacc;
    do_reset();
    start_collect();
    last = 1'b0; runlen = 1; waitc = 0; got = 0; acc = '0; nacc = 0; tval = 1'b0;
    for (int i = 0; i < nbits + 16; i++) begin
      if (i < nbits) begin
        b = 1'($urandom_range(0, 1));
        if (b == last && runlen >= RL - 1) b = ~b;
      end else begin
        if (i == nbits) tval = ~last;
        b = tval ^ 1'(((i - nbits) / 2) % 2);
      end
      runlen = (b == last) ? runlen + 1 : 1;
      last = b;
      q.push_back(b);
      if (i % 2 == 1 && q[i-1] != b) begin
        acc = {acc[6:0], q[i-1]};
        nacc++;
        if (nacc == 8) begin
          expq.push_back(acc);
          nacc = 0;
        end
      end
      ready_i = (waitc >= 5) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      if (valid_o && ready_i) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_extra actual word %0h required none", data_o);
        end else begin
          chk("rnd_word", 64'(data_o), 64'(expq.pop_front()));
          got++;
        end
      end
      waitc = (valid_o && !ready_i) ? waitc + 1 : 0;
      drive(b);
    end
    ready_i = 1'b0;
    chk("rnd_drain", 64'(expq.size()), 64'(0));
    chk("rnd_any", 64'(got > 0), 64'(1));
    chk("rnd_health", 64'(health_fail_o), 64'(0));
  endtask

  initial begin
    vecs[0] = '{24'b100001111010000101111001, 24, 8'hB2};
    vecs[1] = '{{16'b1010101010101010, 8'h00}, 16, 8'hFF};
    vecs[2] = '{{16'b0101010101010101, 8'h00}, 16, 8'h00};
    vecs[3] = '{{16'b1001100110011001, 8'h00}, 16, 8'hAA};
    vecs[4] = '{24'b111000010100101110010110, 24, 8'h99};

    // Reset and warm-up
    do_reset();
    chk("rst_trng_en", 64'(trng_en), 64'(0));
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_data", 64'(data_o), 64'(0));
    chk("rst_health", 64'(health_fail_o), 64'(0));
    enable = 1'b1;
    drive(1'b0);
    chk("en_trng_en", 64'(trng_en), 64'(1));
    drive(1'b1); drive(1'b0); drive(1'b1);
    chk("warmup_valid", 64'(valid_o), 64'(0));

    // Table-driven words with latency, hold and accept
    for (int k = 0; k < 5; k++) begin
      do_reset();
      start_collect();
      for (int i = 0; i < vecs[k].n; i++) drive(vecs[k].bits[23-i]);
      drive_idle(2);
      chk("lat_early", 64'(valid_o), 64'(0));
      drive_idle(1);
      chk("lat_valid", 64'(valid_o), 64'(1));
      chk("word", 64'(data_o), 64'(vecs[k].exp));
      drive_idle(1);
      for (int h = 0; h < 5; h++) begin
        drive_idle(2);
        chk("hold", 64'({valid_o, data_o}), 64'({1'b1, vecs[k].exp}));
      end
      ready_i = 1'b1;
      drive_idle(1);
      chk("accept_fall", 64'(valid_o), 64'(0));
      ready_i = 1'b0;
      drive_idle(1);
    end

    // Backpressure: 2.5 words with the first unconsumed
    do_reset();
    start_collect();
    drive_word(8'hC5);
    drive_word(8'h3A);
    for (int i = 0; i < 4; i++) drive_pair(1'b1);
    drive_idle(8);
    chk("bp_first", 64'({valid_o, data_o}), 64'({1'b1, 8'hC5}));
    ready_i = 1'b1;
    drive_idle(1);
    chk("bp_second", 64'({valid_o, data_o}), 64'({1'b1, 8'h3A}));
    ready_i = 1'b0;
    drive_idle(1);
    chk("bp_second_hold", 64'({valid_o, data_o}), 64'({1'b1, 8'h3A}));
    ready_i = 1'b1;
    drive_idle(1);
    chk("bp_accept2", 64'(valid_o), 64'(0));
    ready_i = 1'b0;
    drive_idle(1);
    drive_word(8'h96);
    drive_idle(6);
    chk("bp_third", 64'({valid_o, data_o}), 64'({1'b1, 8'h96}));

    // Health test: 5 repeats pass, 6 repeats trip
    do_reset();
    start_collect();
    drive_word(8'h5C);
    drive_idle(6);
    chk("hf_pending", 64'(valid_o), 64'(1));
    drive(1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1);
    drive(1'b0);
    drive_idle(10);
    chk("hf_five_ok", 64'(health_fail_o), 64'(0));
    drive(1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1);
    drive(1'b0);
    drive(1'b1);
    chk("hf_not_yet", 64'(health_fail_o), 64'(0));
    drive(1'b0);
    chk("hf_trip", 64'({health_fail_o, trng_en, valid_o}), 64'(3'b100));
    drive(1'b1); drive(1'b0);
    chk("hf_sticky", 64'({health_fail_o, trng_en}), 64'(2'b10));
    enable = 1'b0;
    drive(1'b0);
    chk("hf_idle", 64'({health_fail_o, trng_en}), 64'(2'b10));
    enable = 1'b1;
    drive(1'b1);
    chk("hf_clear", 64'({health_fail_o, trng_en}), 64'(2'b01));

    // Enable drop with pending word and partial word
    do_reset();
    start_collect();
    drive_word(8'h3C);
    drive_idle(6);
    chk("ed_pending", 64'({valid_o, data_o}), 64'({1'b1, 8'h3C}));
    for (int i = 0; i < 5; i++) drive_pair(1'(i % 2));
    enable = 1'b0;
    drive_idle(1);
    chk("ed_trng_en", 64'(trng_en), 64'(0));
    chk("ed_keep", 64'({valid_o, data_o}), 64'({1'b1, 8'h3C}));
    drive_idle(3);
    chk("ed_keep_later", 64'({valid_o, data_o}), 64'({1'b1, 8'h3C}));
    ready_i = 1'b1;
    drive_idle(1);
    chk("ed_accept", 64'(valid_o), 64'(0));
    ready_i = 1'b0;
    drive_idle(1);
    start_collect();
    drive_word(8'hE1);
    drive_idle(6);
    chk("ed_fresh", 64'({valid_o, data_o}), 64'({1'b1, 8'hE1}));

    // Asynchronous reset between edges
    do_reset();
    start_collect();
    drive_word(8'h7B);
    drive_idle(6);
    chk("ar_pending", 64'(valid_o), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("ar_outputs", 64'({trng_en, valid_o, health_fail_o, data_o}), 64'(0));
    reset = 1'b0;
    enable = 1'b0;
    tick();

    // Randomized streams against the list model
    for (int r = 0; r < 3; r++) rnd_round(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trng_collector.md
Name: trng_collector

Overview:
- Consumes the raw 1-bit `trng_out` stream of the ring-oscillator TRNG macro and drives that macro's `trng_en`.
- Synchronises the stream, discards a warm-up period, runs a repetition-count health test, and applies a von Neumann debiaser.
- Packs the debiased bits into WORD_WIDTH words and presents them on a valid/ready interface to the SoC peripheral bus.

Parameters:
- WORD_WIDTH, 32, width of output word; legal range 8..64.
- WARMUP_CYCLES, 256, raw samples discarded after enable before collection starts; must be ≥1.
- REP_LIMIT, 32, consecutive identical raw bits that trip the health test; must be ≥2.

Ports:
- clk  input  1  system clock; also the TRNG sampling clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  software enable.
- trng_en  output  1  enable to the TRNG oscillators.
- trng_bit  input  1  raw `trng_out` from the TRNG macro.
- data_o  output  WORD_WIDTH  random word.
- valid_o  output  1  data_o holds an unconsumed word.
- ready_i  input  1  consumer accepts data_o.
- health_fail_o  output  1  repetition test tripped; sticky.

Behaviour:
- Reset values: trng_en=0, data_o=0, valid_o=0, health_fail_o=0, state=IDLE, all counters and synchroniser flops 0.
- Synchroniser: trng_bit passes through two flops. The result is `raw`, with 2-cycle latency.
- trng_en is registered:
  - It is 1 in WARMUP and COLLECT.
  - It is 0 in IDLE and FAIL.
- FSM states: IDLE, WARMUP, COLLECT, FAIL.
  - IDLE -> WARMUP when enable=1. On this transition: clear the warm-up counter, pair phase, bit count and health_fail_o.
  - WARMUP: count one raw sample per cycle. Go to COLLECT in the cycle after WARMUP_CYCLES samples have been counted.
  - COLLECT -> FAIL when the repetition counter reaches REP_LIMIT.
  - FAIL: health_fail_o=1. Stays in FAIL until enable=0, then goes to IDLE. health_fail_o stays 1 in IDLE until the next enable.
  - Any state except IDLE -> IDLE when enable=0. On this transition clear the pair phase, bit count, shift register and repetition counter.
- Repetition test (COLLECT only):
  - run=1 on entry to COLLECT.
  - run increments when raw equals the previous raw and resets to 1 otherwise; it saturates.
  - When run==REP_LIMIT, enter FAIL on the next edge.
  - On entering FAIL, valid_o is forced to 0 and the partial word is dropped.
- Von Neumann debiaser (COLLECT only):
  - Alternating phase: phase 0 stores raw as `first`; phase 1 evaluates the pair (first, raw).
  - Pair 10 emits bit 1; pair 01 emits bit 0; pairs 00 and 11 emit nothing.
  - Phase toggles every COLLECT cycle.
- Packing:
  - Each emitted bit shifts into the LSB: sh <= {sh[W-2:0], bit}.
  - cnt counts bits, width $clog2(WORD_WIDTH+1).
  - When cnt==WORD_WIDTH and the output slot is free (valid_o=0, or valid_o&&ready_i in the same cycle), then in the same cycle: data_o<=sh, valid_o<=1, cnt<=0.
  - A bit emitted in that same cycle becomes bit 0 of the next word (cnt<=1).
- Backpressure: if cnt==WORD_WIDTH and the slot is occupied, the shift register holds and newly emitted bits are dropped. The pair phase and the repetition test keep running.
- Handshake:
  - Transfer occurs on valid_o&&ready_i.
  - data_o is stable while valid_o=1 and not accepted.
  - valid_o falls the cycle after acceptance unless a new word is loaded.
  - ready_i is ignored while valid_o=0.
- enable=0 does not clear a pending output word; it remains valid until consumed. FAIL is the only path that clears it.
- Latency from the 2nd bit of the final pair at trng_bit to valid_o=1: 4 cycles (2 sync, 1 evaluate/shift, 1 load).

Decomposition:
- Package trng_pkg:
  - State enum `trng_state_e` {IDLE, WARMUP, COLLECT, FAIL}.
  - Default constants for WORD_WIDTH, WARMUP_CYCLES and REP_LIMIT.
  - Helper function for the counter width.
- Sub-module trng_vn_debias:
  - Inputs: clk, reset, clear, en, raw.
  - Outputs: bit_valid, bit_out.
  - Contains the phase flop and the first-bit flop.
- The top level holds the synchroniser, FSM, repetition test, packer and output register.

Test Plan (WORD_WIDTH=8, WARMUP_CYCLES=4, REP_LIMIT=6):
- Reset/idle: reset pulse with enable=0 -> all outputs 0. enable=1 -> trng_en=1 the next cycle; no valid_o during the 4 warm-up samples.
- Debias/pack: after warm-up, drive raw pairs 10,01,10,10,01,01,10,01 interleaved with 00/11 pairs -> one word, data_o=8'b10110010, valid_o=1. Hold ready_i=0 for 10 cycles; data_o stays stable. Pulse ready_i -> valid_o falls next cycle.
- Backpressure: ready_i=0 while 2.5 words of pairs are supplied -> first word held on data_o. Second word is complete in sh; later bits are dropped. Accept the first word -> second word loads the same cycle, and the following word starts with cnt=0.
- Health fail: drive 6 consecutive 1s in COLLECT -> FAIL, health_fail_o=1, trng_en=0, valid_o=0. enable=0 then 1 -> health_fail_o clears on entering WARMUP.
- Enable drop mid-word: deassert enable after 5 bits with a valid word pending -> IDLE, trng_en=0. The pending word stays valid and is accepted later. Re-enable -> a fresh word is built from 0 bits.
- Async reset mid-operation: assert reset between clock edges in COLLECT -> outputs 0 immediately, without waiting for clk.
